// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and helpers: receiver state encoding,
//               parity mode codes and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver states; PARITY only reachable when the parity checker is built in
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Parity mode codes for the PARITY parameter
    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Bits needed to count 0..n-1, never less than one
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Clock divider producing oversample ticks, plus a per-bit
//               oversample counter. centre marks the tick at count
//               OVERSAMPLE/2+1, the last of the three majority samples.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 10,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick,
    output logic centre
);

    localparam int unsigned c_DIV_W = cnt_width(TICK_DIV);
    localparam int unsigned c_OS_W  = cnt_width(OVERSAMPLE);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(TICK_DIV - 1);
    localparam logic [c_OS_W-1:0]  c_OS_LAST   = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_OS_W-1:0]  c_OS_CENTRE = c_OS_W'(OVERSAMPLE / 2 + 1);

    logic [c_DIV_W-1:0] r_div;
    logic [c_OS_W-1:0]  r_os;

    // Divider and oversample counter; restart re-aligns both to a start edge
    always_ff @(posedge clk) begin
        if (!rst || restart) begin
            r_div <= '0;
            r_os  <= '0;
        end else if (r_div == c_DIV_LAST) begin
            r_div <= '0;
            r_os  <= (r_os == c_OS_LAST) ? '0 : r_os + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign tick   = (r_div == c_DIV_LAST);
    assign centre = tick && (r_os == c_OS_CENTRE);

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg
// Description : Parametrised UART receiver with 3-sample majority vote,
//               framing/parity/overrun reporting and a valid/ready output
//               register. Optional parity checking is built in when the
//               macro UART_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 10_000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned c_TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned c_CNT_W    = cnt_width(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_STOP_LAST = c_CNT_W'(STOP_BITS - 1);

    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]           r_samp;
    logic                 w_tick, w_centre, w_restart, w_done, w_bit;
    uart_state_t          r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_ferr, w_ferr_nxt;
    logic                 r_out_valid, r_frame_err, r_overrun;
    logic [DATA_BITS-1:0] r_out_data;
`ifdef UART_PARITY_EN
    localparam bit c_PAR_ON = (PARITY != PAR_NONE);
    logic                 r_perr, w_perr_nxt, r_parity_err;
`else
    logic                 w_unused_parity;
    assign w_unused_parity = (PARITY != PAR_NONE);
`endif

    uart_baud_tick #(
        .TICK_DIV   (c_TICK_DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick),
        .centre  (w_centre)
    );

    // Two-flop synchroniser plus edge-history flop; idle-high after reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Keep the two samples preceding the centre tick for the majority vote
    always_ff @(posedge clk) begin
        if (!rst)        r_samp <= 2'b11;
        else if (w_tick) r_samp <= {r_samp[0], r_rx_sync};
    end

    assign w_bit = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_rx_sync) | (r_samp[0] & r_rx_sync);

    // Frame FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ferr    <= 1'b0;
`ifdef UART_PARITY_EN
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ferr    <= w_ferr_nxt;
`ifdef UART_PARITY_EN
            r_perr    <= w_perr_nxt;
`endif
        end
    end

    // Next-state logic: all decisions are taken on the centre tick of a bit
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ferr_nxt    = r_ferr;
`ifdef UART_PARITY_EN
        w_perr_nxt    = r_perr;
`endif
        w_restart     = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_state_nxt   = ST_START;
                    w_restart     = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_ferr_nxt    = 1'b0;
`ifdef UART_PARITY_EN
                    w_perr_nxt    = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (w_centre) w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_centre) begin
                    w_shift_nxt = {w_bit, r_shift[DATA_BITS-1:1]};
                    if (r_bit_cnt == c_DATA_LAST) begin
                        w_bit_cnt_nxt = '0;
`ifdef UART_PARITY_EN
                        w_state_nxt   = c_PAR_ON ? ST_PARITY : ST_STOP;
`else
                        w_state_nxt   = ST_STOP;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                // Odd ones-count over data+parity is an error in even mode, and vice versa
                if (w_centre) begin
                    w_perr_nxt  = (^r_shift ^ w_bit) ^ (PARITY == PAR_ODD);
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_centre) begin
                    if (!w_bit) w_ferr_nxt = 1'b1;
                    if (r_bit_cnt == c_STOP_LAST) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output register: load on completion if free or being drained, else flag overrun
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                if (!r_out_valid || out_ready) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_shift;
                    r_frame_err  <= w_ferr_nxt;
`ifdef UART_PARITY_EN
                    r_parity_err <= r_perr;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid  <= 1'b0;
                r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);
`ifdef UART_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_cfg
// Description : Self-checking bench for uart_rx_cfg. Instance A is 8N1,
//               instance B is 7 data / 2 stop; with UART_PARITY_EN an even
//               parity instance C is added. Frames are built bit by bit and
//               expected words come from a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int BIT_CLKS = 160;   // 100 MHz / 625 kBd

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rx_a, rx_b, rdy_a, rdy_b;
    logic va, fa, pa, oa, ba;
    logic [7:0] da;
    logic vb, fb, pb, ob, bb;
    logic [6:0] db;

    int tests = 0;
    int fails = 0;
    int ovr_a = 0;
    int ovr_b = 0;
    int rd[3] = '{0, 0, 0};
    logic [10:0] got_a[$];
    logic [10:0] got_b[$];
    logic [10:0] exp_q[$];

    uart_rx_cfg #(
        .CLK_FREQ(100_000_000), .BAUD(625_000), .DATA_BITS(8),
        .STOP_BITS(1), .PARITY(0), .OVERSAMPLE(16)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx_a), .out_valid(va), .out_ready(rdy_a),
        .out_data(da), .frame_err(fa), .parity_err(pa), .overrun(oa), .busy(ba)
    );

    uart_rx_cfg #(
        .CLK_FREQ(100_000_000), .BAUD(625_000), .DATA_BITS(7),
        .STOP_BITS(2), .PARITY(0), .OVERSAMPLE(16)
    ) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .out_valid(vb), .out_ready(rdy_b),
        .out_data(db), .frame_err(fb), .parity_err(pb), .overrun(ob), .busy(bb)
    );

`ifdef UART_PARITY_EN
    logic rx_c, rdy_c, vc, fc, pc, oc, bc;
    logic [7:0] dc;
    int ovr_c = 0;
    logic [10:0] got_c[$];

    uart_rx_cfg #(
        .CLK_FREQ(100_000_000), .BAUD(625_000), .DATA_BITS(8),
        .STOP_BITS(1), .PARITY(1), .OVERSAMPLE(16)
    ) dut_c (
        .clk(clk), .rst(rst), .rx(rx_c), .out_valid(vc), .out_ready(rdy_c),
        .out_data(dc), .frame_err(fc), .parity_err(pc), .overrun(oc), .busy(bc)
    );

    always @(negedge clk) begin
        if (vc && rdy_c) got_c.push_back({pc, fc, 1'b0, dc});
        if (oc) ovr_c <= ovr_c + 1;
    end
`endif

    // Collect accepted words and overrun pulses mid-cycle, away from the edge
    always @(negedge clk) begin
        if (va && rdy_a) got_a.push_back({pa, fa, 1'b0, da});
        if (vb && rdy_b) got_b.push_back({pb, fb, 2'b00, db});
        if (oa) ovr_a <= ovr_a + 1;
        if (ob) ovr_b <= ovr_b + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end (tests=%0d)", tests);
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected delivered word {parity_err, frame_err, data} for one frame
    function automatic logic [10:0] model(input logic [8:0] data, input int nbits,
                                          input logic stop_ok, input logic par_present,
                                          input logic par_bit, input int par_mode);
        logic [8:0] d;
        int ones;
        logic perr;
        d    = data & 9'((1 << nbits) - 1);
        ones = $countones(d) + int'(par_bit);
        perr = 1'b0;
        if (par_present) perr = (par_mode == 1) ? (ones % 2 != 0) : (ones % 2 == 0);
        return {perr, ~stop_ok, d};
    endfunction

    function automatic int got_n(input int which);
        case (which)
            0: return got_a.size();
            1: return got_b.size();
`ifdef UART_PARITY_EN
            2: return got_c.size();
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic [10:0] got_at(input int which, input int i);
        case (which)
            0: return got_a[i];
            1: return got_b[i];
`ifdef UART_PARITY_EN
            2: return got_c[i];
`endif
            default: return '0;
        endcase
    endfunction

    task automatic set_rx(input int which, input logic v);
        case (which)
            0: rx_a = v;
            1: rx_b = v;
`ifdef UART_PARITY_EN
            2: rx_c = v;
`endif
            default: ;
        endcase
    endtask

    // Drive one frame; stall randomly drops ready on instance A while it runs
    task automatic send(input int which, input int nbits, input int nstop,
                        input logic [8:0] data, input logic stop_val,
                        input logic par_present, input logic par_bit, input bit stall);
        logic [15:0] fr;
        int n;
        fr = '0;
        n  = 1;
        for (int i = 0; i < nbits; i++) begin fr[n] = data[i]; n++; end
        if (par_present) begin fr[n] = par_bit; n++; end
        for (int s = 0; s < nstop; s++) begin fr[n] = stop_val; n++; end
        for (int b = 0; b < n; b++) begin
            set_rx(which, fr[b]);
            for (int k = 0; k < BIT_CLKS; k++) begin
                cyc(1);
                if (stall) rdy_a = ($urandom_range(0, 3) != 0);
            end
        end
        set_rx(which, 1'b1);
        if (stall) rdy_a = 1'b1;
    endtask

    // Wait (bounded) for all pending expected words, then compare them in order
    task automatic expect_frames(input int which, input string tag);
        int need;
        int t;
        logic [10:0] e;
        need = rd[which] + exp_q.size();
        t = 0;
        while (got_n(which) < need && t < 4000) begin cyc(1); t++; end
        chk({tag, "_count"}, got_n(which), need);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd[which] < got_n(which)) begin
                chk(tag, got_at(which, rd[which]), e);
                rd[which]++;
            end
        end
        rd[which] = got_n(which);
    endtask

    initial begin
        logic [8:0] d;
        logic       s;

        rst = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
`ifdef UART_PARITY_EN
        rx_c = 1'b1; rdy_c = 1'b1;
`endif
        cyc(5);
        chk("rst_valid", va, 0);
        chk("rst_data", da, 0);
        chk("rst_ferr", fa, 0);
        chk("rst_perr", pa, 0);
        chk("rst_overrun", oa, 0);
        chk("rst_busy", ba, 0);
        chk("rst_valid_b", vb, 0);
        rst = 1'b1;
        cyc(10);

        // 8N1 single word
        send(0, 8, 1, 9'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(model(9'hA5, 8, 1'b1, 1'b0, 1'b0, 0));
        expect_frames(0, "a5");
        cyc(20);

        // 7 data / 2 stop, back-to-back
        send(1, 7, 2, 9'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1, 7, 2, 9'h2A, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(model(9'h55, 7, 1'b1, 1'b0, 1'b0, 0));
        exp_q.push_back(model(9'h2A, 7, 1'b1, 1'b0, 1'b0, 0));
        expect_frames(1, "b2b");

        // Short low glitch rejected in START
        rx_a = 1'b0;
        cyc(20);
        chk("glitch_busy_hi", ba, 1);
        cyc(20);
        rx_a = 1'b1;
        cyc(300);
        chk("glitch_busy_lo", ba, 0);
        expect_frames(0, "glitch");

        // Stop bit forced low
        send(0, 8, 1, 9'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(model(9'h3C, 8, 1'b0, 1'b0, 1'b0, 0));
        cyc(40);
        expect_frames(0, "ferr");

        // Break: one zero word with framing error, then quiet until a new edge
        rx_a = 1'b0;
        cyc(12 * BIT_CLKS);
        rx_a = 1'b1;
        cyc(100);
        exp_q.push_back(model(9'h000, 8, 1'b0, 1'b0, 1'b0, 0));
        expect_frames(0, "break");
        cyc(300);
        chk("break_idle", ba, 0);
        expect_frames(0, "break_quiet");

        // Random 8N1 words with random consumer stalls and random stop errors
        for (int i = 0; i < 10; i++) begin
            d = 9'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            send(0, 8, 1, d, s, 1'b0, 1'b0, 1'b1);
            exp_q.push_back(model(d, 8, s, 1'b0, 1'b0, 0));
            cyc($urandom_range(20, 80));
        end
        expect_frames(0, "rand_a");

        // Random 7-bit / 2-stop words
        for (int i = 0; i < 6; i++) begin
            d = 9'($urandom_range(0, 127));
            s = ($urandom_range(0, 3) != 0);
            send(1, 7, 2, d, s, 1'b0, 1'b0, 1'b0);
            exp_q.push_back(model(d, 7, s, 1'b0, 1'b0, 0));
            cyc($urandom_range(20, 80));
        end
        expect_frames(1, "rand_b");

        // Overrun: consumer stalled across two frames
        rdy_a = 1'b0;
        send(0, 8, 1, 9'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        send(0, 8, 1, 9'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(20);
        chk("ovr_valid", va, 1);
        chk("ovr_data", da, 8'h11);
        chk("ovr_pulses", ovr_a, 1);
        rdy_a = 1'b1;
        cyc(2);
        chk("ovr_drained", va, 0);
        exp_q.push_back(model(9'h11, 8, 1'b1, 1'b0, 1'b0, 0));
        expect_frames(0, "ovr");

        // Reset in mid-frame, then a clean word
        rx_a = 1'b0;
        cyc(400);
        chk("midrst_busy_hi", ba, 1);
        rst  = 1'b0;
        rx_a = 1'b1;
        cyc(3);
        chk("midrst_busy_lo", ba, 0);
        chk("midrst_valid", va, 0);
        rst = 1'b1;
        cyc(50);
        send(0, 8, 1, 9'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(model(9'h5A, 8, 1'b1, 1'b0, 1'b0, 0));
        expect_frames(0, "after_rst");

`ifdef UART_PARITY_EN
        // Even parity: 0x03 with parity 1 is wrong, with parity 0 is right
        send(2, 8, 1, 9'h03, 1'b1, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(model(9'h03, 8, 1'b1, 1'b1, 1'b1, 1));
        send(2, 8, 1, 9'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(9'h03, 8, 1'b1, 1'b1, 1'b0, 1));
        for (int i = 0; i < 3; i++) begin
            d = 9'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            send(2, 8, 1, d, 1'b1, 1'b1, s, 1'b0);
            exp_q.push_back(model(d, 8, 1'b1, 1'b1, s, 1));
        end
        expect_frames(2, "parity");
        chk("ovr_c_none", ovr_c, 0);
        chk("busy_c_end", bc, 0);
`endif

        chk("ovr_b_none", ovr_b, 0);
        chk("ovr_a_total", ovr_a, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
